// File: rtl/intarziere_pkg.sv
// Shared types and constants for the multi-channel delayed-pulse generator.
package intarziere_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } stare_t;

    localparam logic MOD_LEVEL = 1'b0;
    localparam logic MOD_EDGE  = 1'b1;

    function automatic logic este_ocupat(input stare_t s);
        return (s == ST_WAIT) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/intarziere_canal.sv
// One channel: input synchroniser, falling-edge detect, tick counter and
// IDLE/WAIT/ACTIVE/DONE sequencer with registered outputs.
module intarziere_canal
    import intarziere_pkg::*;
#(
    parameter int DELAY = 1,
    parameter int HOLD  = 2,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_semnal,
    input  logic i_mod_edge,
    output logic o_semnal_out,
    output logic o_busy,
    output logic o_done_pulse
);

    localparam logic [CNT_W-1:0] L_DELAY = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] L_END   = CNT_W'(DELAY + HOLD);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    stare_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;

    stare_t           w_state_nxt;
    stare_t           w_adv_state;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_adv_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_mode_nxt;
    logic             w_mode_eff;
    logic             w_fall;

    // Two-flop synchroniser plus previous-value flop, all idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_semnal;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall     = r_prev & ~r_sync2;
    // The live mode input only matters when starting from IDLE; otherwise the captured mode rules.
    assign w_mode_eff = (r_state == ST_IDLE) ? i_mod_edge : r_mode;
    assign w_cnt_inc  = (r_cnt >= L_END) ? L_END : (r_cnt + L_ONE);

    // Tick-driven progress through WAIT and ACTIVE, shared by both modes.
    always_comb begin
        w_adv_state = r_state;
        w_adv_cnt   = r_cnt;
        if (i_tick) begin
            w_adv_cnt = w_cnt_inc;
            if (w_cnt_inc >= L_END) begin
                w_adv_state = ST_DONE;
            end else if (w_cnt_inc >= L_DELAY) begin
                w_adv_state = ST_ACTIVE;
            end else begin
                w_adv_state = ST_WAIT;
            end
        end else begin
            w_adv_state = r_state;
        end
    end

    // Next-state selection: level abort and edge retrigger both outrank tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        if (w_mode_eff == MOD_LEVEL) begin
            if (r_sync2) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = '0;
                        w_mode_nxt  = MOD_LEVEL;
                    end
                    ST_WAIT, ST_ACTIVE: begin
                        w_state_nxt = w_adv_state;
                        w_cnt_nxt   = w_adv_cnt;
                    end
                    ST_DONE: begin
                        w_state_nxt = ST_DONE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end else begin
            if (w_fall) begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
                if (r_state == ST_IDLE) begin
                    w_mode_nxt = MOD_EDGE;
                end else begin
                    w_mode_nxt = r_mode;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_IDLE;
                    end
                    ST_WAIT, ST_ACTIVE: begin
                        w_state_nxt = w_adv_state;
                        w_cnt_nxt   = w_adv_cnt;
                    end
                    ST_DONE: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // Sequencer state, counter and captured mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MOD_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Outputs decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_semnal_out <= 1'b0;
            o_busy       <= 1'b0;
            o_done_pulse <= 1'b0;
        end else begin
            o_semnal_out <= (w_state_nxt == ST_ACTIVE);
            o_busy       <= este_ocupat(w_state_nxt);
            o_done_pulse <= (w_state_nxt == ST_DONE) && (r_state == ST_ACTIVE);
        end
    end

endmodule

// File: rtl/intarziere_canale.sv
// Top: N_CH independent delayed-pulse channels sharing clock, reset and tick.
module intarziere_canale
    import intarziere_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DELAY = 1,
    parameter int HOLD  = 2,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] semnal,
    input  logic [N_CH-1:0] mod_edge,
    output logic [N_CH-1:0] semnal_out,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] done_pulse
);

    // The counter must be able to hold DELAY+HOLD without wrapping.
    if (DELAY < 1) begin : g_chk_delay
        $error("intarziere_canale: DELAY must be at least 1");
    end
    if (HOLD < 1) begin : g_chk_hold
        $error("intarziere_canale: HOLD must be at least 1");
    end
    if ((DELAY + HOLD) >= (1 << CNT_W)) begin : g_chk_cnt
        $error("intarziere_canale: DELAY+HOLD does not fit in CNT_W bits");
    end
    if (N_CH < 1) begin : g_chk_nch
        $error("intarziere_canale: N_CH must be at least 1");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        intarziere_canal #(
            .DELAY (DELAY),
            .HOLD  (HOLD),
            .CNT_W (CNT_W)
        ) u_canal (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_tick       (tick),
            .i_semnal     (semnal[g]),
            .i_mod_edge   (mod_edge[g]),
            .o_semnal_out (semnal_out[g]),
            .o_busy       (busy[g]),
            .o_done_pulse (done_pulse[g])
        );
    end

endmodule

// File: doc/intarziere_canale.md
# intarziere_canale

Parametrised multi-channel delayed-pulse generator for the line-sensor path. Each channel watches one sensor level. When the sensor drops low, the channel waits DELAY ticks and then drives its output high for HOLD ticks. Timing runs from a one-cycle tick enable on the system clock rather than a divided clock. Each channel can run in level mode (abort when the input returns high) or edge mode (one-shot, retriggerable on falling edges).

## Interface
- N_CH, 4: number of independent channels.
- DELAY, 1: ticks from start until output asserts; legal range is 1 or more.
- HOLD, 2: ticks the output stays high; legal range is 1 or more.
- CNT_W, 4: tick counter width; elaboration fails unless DELAY+HOLD < 2**CNT_W.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz strobe).
- semnal  in  N_CH  raw sensor levels, asynchronous; idle level is high.
- mod_edge  in  N_CH  per-channel mode: 0 = level, 1 = edge one-shot.
- semnal_out  out  N_CH  delayed pulse outputs.
- busy  out  N_CH  channel is in WAIT or ACTIVE.
- done_pulse  out  N_CH  one-cycle strobe on entry to DONE.

## Operation
- Input path per channel:
  - 2-flop synchroniser, both flops reset to 1.
  - One further flop holds the previous synchronised value for falling-edge detect.
- Per-channel FSM states: IDLE, WAIT, ACTIVE, DONE.
- Saturating counter cnt, CNT_W bits, counts ticks since start.
- Start condition:
  - Level mode: synchronised input is low while in IDLE.
  - Edge mode: falling edge detected in any state.
  - On start: cnt=0, state=WAIT. No tick is required.
  - mod_edge is captured on each start and held in a mode register; changes while busy are ignored.
- Advancing:
  - Counting happens only on cycles with tick=1 while in WAIT or ACTIVE; cnt increments by 1.
  - cnt reaches DELAY: WAIT to ACTIVE.
  - cnt reaches DELAY+HOLD: ACTIVE to DONE.
  - cnt saturates at DELAY+HOLD.
- Abort (level mode only): synchronised input high in any state means IDLE, cnt=0, with priority over tick.
- DONE exit:
  - Level mode: DONE holds until the input returns high, then IDLE. There is no re-fire while the input stays low.
  - Edge mode: DONE goes to IDLE on the next clk.
- Retrigger (edge mode): a falling edge in WAIT, ACTIVE or DONE restarts (cnt=0, WAIT) and takes priority over a coincident tick. Rising edges are ignored.
- Outputs:
  - semnal_out = 1 exactly while in ACTIVE, i.e. DELAY <= cnt < DELAY+HOLD.
  - busy = WAIT or ACTIVE.
  - done_pulse = 1 on the cycle after the ACTIVE-to-DONE edge only.
  - All outputs are registered.
- Channels are fully independent and share only clk, rst_n and tick.

## Timing
- Reset values:
  - semnal_out=0, busy=0, done_pulse=0.
  - All states IDLE, cnt=0.
  - Sync and previous-value flops = 1.
  - Reset applies immediately on assertion and may occur mid-sequence.
- Input latency: a level sampled at edge k is seen by the FSM at edge k+2, so state and busy update at edge k+2.
- Output timing:
  - semnal_out rises on the clk edge of the DELAY-th tick after start.
  - semnal_out falls on the edge of the (DELAY+HOLD)-th tick.
  - Pulse width = HOLD tick periods.
- Simultaneous events:
  - Level abort beats tick.
  - Edge retrigger beats tick.
  - tick together with start does not count; the first increment is on the next tick.
- Zero ticks means the channel stays in WAIT indefinitely; busy=1.

## Structure
- Package intarziere_pkg:
  - state enum typedef (IDLE, WAIT, ACTIVE, DONE).
  - MOD_LEVEL/MOD_EDGE constants.
- Sub-module intarziere_canal: one channel (synchroniser, edge detect, FSM, counter).
- Top: generates N_CH instances and checks parameters at elaboration.

## Test plan
Defaults for all scenarios: N_CH=4, DELAY=1, HOLD=2, tick every 10 clk.
- Reset then idle: semnal=4'hF, no activity -> all outputs 0, busy=0 indefinitely.
- Level mode ch0: semnal[0] held low -> busy at +2 clk; semnal_out[0] high from 1st to 3rd tick (20 clk); done_pulse[0] one cycle; stays DONE, output 0, until semnal[0] goes high.
- Level abort: semnal[0] goes high during ACTIVE -> semnal_out[0]=0 and busy=0 at +2 clk; low again -> full sequence restarts.
- Edge mode ch1: 1-clk low glitch on semnal[1] -> full 2-tick pulse; second falling edge during ACTIVE -> restart, so the output goes low and rises again 1 tick later.
- Coincidence: falling edge reaches the FSM on the same cycle as tick -> cnt stays 0; the pulse starts on the following tick.
- Async reset asserted mid-ACTIVE on all channels -> outputs 0 immediately; after release no pulse until a new start condition.
